fp_add_result_stage: RTL and testbench



---
 rtl/fp_add_result_stage.sv | 111 +++++++++++
 tb/tb_fp_add_result_stage.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/fp_add_result_stage.sv
// Registered result stage behind the FP adder: a small FIFO of {result, exception, tag}
// with a valid/ready output and sticky fflags. Optional macro: FP_ADD_RESULT_CANON_NAN_EN.
module fp_add_result_stage #(
    parameter int exp_width  = 8,
    parameter int frac_width = 23,
    parameter int depth      = 2,
    parameter int tag_width  = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [exp_width+frac_width:0]   in_result,
    input  logic [4:0]                      in_exception,
    input  logic [tag_width-1:0]            in_tag,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [exp_width+frac_width:0]   out_result,
    output logic [4:0]                      out_exception,
    output logic [tag_width-1:0]            out_tag,
    output logic [4:0]                      fflags,
    input  logic                            fflags_clr
);

    localparam int W     = exp_width + frac_width + 1;
    localparam int PTR_W = $clog2(depth);
    localparam int CNT_W = $clog2(depth + 1);

    typedef struct packed {
        logic [W-1:0]         result;
        logic [4:0]           exception;
        logic [tag_width-1:0] tag;
    } entry_t;

    entry_t             mem [depth];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   count;
    logic               push;
    logic               pop;
    entry_t             wr_entry;
    entry_t             head;

    function automatic logic [W-1:0] store_result(input logic [W-1:0] r);
`ifdef FP_ADD_RESULT_CANON_NAN_EN
        // Any NaN (max exponent, nonzero fraction) collapses to the positive quiet NaN.
        if ((&r[W-2 -: exp_width]) && (|r[frac_width-1:0]))
            return {1'b0, {exp_width{1'b1}}, 1'b1, {(frac_width-1){1'b0}}};
`endif
        return r;
    endfunction

    // in_ready depends on stored count only, so out_ready never reaches it combinationally.
    assign in_ready  = (count < CNT_W'(depth));
    assign out_valid = (count != '0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    always_comb begin
        wr_entry.result    = store_result(in_result);
        wr_entry.exception = in_exception;
        wr_entry.tag       = in_tag;
    end

    // NOTE: every variable gets a default before the branch, so no latch is inferred.
    always_comb begin
        head = '0;
        if (out_valid)
            head = mem[rd_ptr];
    end

    assign out_result    = head.result;
    assign out_exception = head.exception;
    assign out_tag       = head.tag;

    // NOTE: storage is not reset; count gates every read, so stale contents are never visible.
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= wr_entry;
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)
                rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // A clear together with a push keeps the new exception bits.
    always_ff @(posedge clk) begin
        if (rst)
            fflags <= '0;
        else if (fflags_clr)
            fflags <= push ? in_exception : 5'b0;
        else if (push)
            fflags <= fflags | in_exception;
    end

endmodule

// File: tb/tb_fp_add_result_stage.sv
// Self-checking bench for fp_add_result_stage: directed literal checks plus randomized
// traffic compared every cycle against a queue-based reference model.
module tb_fp_add_result_stage;

    localparam int EXP   = 8;
    localparam int FRAC  = 23;
    localparam int DEPTH = 2;
    localparam int TAGW  = 4;
    localparam int W     = EXP + FRAC + 1;

    // Exception bit positions as laid out in FloatingPointConsts.svh.
    localparam int FP_INEXACT   = 0;
    localparam int FP_UNDERFLOW = 1;
    localparam int FP_OVERFLOW  = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic [W-1:0]    in_result;
    logic [4:0]      in_exception;
    logic [TAGW-1:0] in_tag;
    logic            out_valid;
    logic            out_ready;
    logic [W-1:0]    out_result;
    logic [4:0]      out_exception;
    logic [TAGW-1:0] out_tag;
    logic [4:0]      fflags;
    logic            fflags_clr;

    fp_add_result_stage #(
        .exp_width(EXP), .frac_width(FRAC), .depth(DEPTH), .tag_width(TAGW)
    ) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_result(in_result), .in_exception(in_exception), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_exception(out_exception), .out_tag(out_tag),
        .fflags(fflags), .fflags_clr(fflags_clr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0]    result;
        logic [4:0]      exception;
        logic [TAGW-1:0] tag;
    } item_t;

    item_t      model_q[$];
    logic [4:0] model_ff = '0;
    bit         model_on = 1'b0;
    int         checks   = 0;
    int         failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic logic [W-1:0] expect_store(input logic [W-1:0] r);
`ifdef FP_ADD_RESULT_CANON_NAN_EN
        if (r[W-2 -: EXP] == {EXP{1'b1}} && r[FRAC-1:0] != 0)
            return {1'b0, {EXP{1'b1}}, 1'b1, {(FRAC-1){1'b0}}};
`endif
        return r;
    endfunction

    // Reference model: a queue of accepted items plus the sticky flag word.
    always @(posedge clk) begin
        bit    acc;
        bit    take;
        item_t it;
        if (rst) begin
            model_q.delete();
            model_ff = '0;
            model_on = 1'b1;
        end else begin
            acc  = in_valid && (model_q.size() < DEPTH);
            take = (model_q.size() != 0) && out_ready;
            if (take)
                void'(model_q.pop_front());
            if (acc) begin
                it.result    = expect_store(in_result);
                it.exception = in_exception;
                it.tag       = in_tag;
                model_q.push_back(it);
            end
            if (fflags_clr)
                model_ff = acc ? in_exception : 5'b0;
            else if (acc)
                model_ff = model_ff | in_exception;
        end
    end

    // Compare process: every cycle after the first reset, away from the rising edge.
    always @(negedge clk) begin
        if (model_on) begin
            check("m_in_ready",  64'(in_ready),  64'(model_q.size() < DEPTH));
            check("m_out_valid", 64'(out_valid), 64'(model_q.size() != 0));
            check("m_fflags",    64'(fflags),    64'(model_ff));
            if (model_q.size() != 0) begin
                check("m_out_result", 64'(out_result),    64'(model_q[0].result));
                check("m_out_exc",    64'(out_exception), 64'(model_q[0].exception));
                check("m_out_tag",    64'(out_tag),       64'(model_q[0].tag));
            end else begin
                check("m_empty_zero", 64'({out_result, out_exception, out_tag}), 64'(0));
            end
        end
    end

    // Advance one clock; returns just after the following falling edge.
    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [W-1:0] r, input logic [4:0] e,
                         input logic [TAGW-1:0] t, input logic ordy, input logic clr);
        in_valid     = v;
        in_result    = r;
        in_exception = e;
        in_tag       = t;
        out_ready    = ordy;
        fflags_clr   = clr;
    endtask

    initial begin
        rst = 1'b1;
        drive(1'b0, '0, '0, '0, 1'b0, 1'b0);
        cyc();
        cyc();
        rst = 1'b0;
        cyc();

        // Idle after reset.
        check("rst_out_valid",  64'(out_valid),  64'd0);
        check("rst_in_ready",   64'(in_ready),   64'd1);
        check("rst_fflags",     64'(fflags),     64'd0);
        check("rst_out_result", 64'(out_result), 64'd0);

        // Single push, one cycle latency, then pop.
        drive(1'b1, 32'h4000_0000, 5'd0, 4'd3, 1'b1, 1'b0);
        cyc();
        drive(1'b0, '0, '0, '0, 1'b1, 1'b0);
        check("single_valid",  64'(out_valid),  64'd1);
        check("single_result", 64'(out_result), 64'h4000_0000);
        check("single_tag",    64'(out_tag),    64'd3);
        cyc();
        check("single_empty",  64'(out_valid),  64'd0);

        // Fill while stalled; third push must be dropped.
        drive(1'b1, 32'h3F80_0000, 5'd0, 4'd1, 1'b0, 1'b0);
        cyc();
        drive(1'b1, 32'h4040_0000, 5'd0, 4'd2, 1'b0, 1'b0);
        cyc();
        check("full_in_ready", 64'(in_ready), 64'd0);
        drive(1'b1, 32'h4080_0000, 5'd0, 4'd7, 1'b0, 1'b0);
        cyc();
        check("stall_head_tag", 64'(out_tag), 64'd1);
        drive(1'b0, '0, '0, '0, 1'b1, 1'b0);
        cyc();
        check("order_tag2",     64'(out_tag),  64'd2);
        check("ready_after_pop", 64'(in_ready), 64'd1);
        cyc();
        check("drain_empty",    64'(out_valid), 64'd0);

        // Sticky flags, then clear together with a push.
        drive(1'b1, 32'h7F80_0000, 5'(1 << FP_OVERFLOW), 4'd4, 1'b1, 1'b0);
        cyc();
        drive(1'b1, 32'h3EAA_AAAB, 5'(1 << FP_INEXACT), 4'd5, 1'b1, 1'b0);
        cyc();
        check("ff_or", 64'(fflags), 64'((1 << FP_OVERFLOW) | (1 << FP_INEXACT)));
        drive(1'b1, 32'h0000_0001, 5'(1 << FP_UNDERFLOW), 4'd6, 1'b1, 1'b1);
        cyc();
        check("ff_clr_push", 64'(fflags), 64'(1 << FP_UNDERFLOW));
        drive(1'b0, '0, '0, '0, 1'b1, 1'b1);
        cyc();
        check("ff_clr_only", 64'(fflags), 64'd0);

        // Reset mid-stream with a full FIFO and in_valid high.
        drive(1'b1, 32'h4100_0000, 5'b10000, 4'd8, 1'b0, 1'b0);
        cyc();
        cyc();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        check("mid_rst_valid",  64'(out_valid), 64'd0);
        check("mid_rst_fflags", 64'(fflags),    64'd0);
        drive(1'b0, '0, '0, '0, 1'b1, 1'b0);
        cyc();
        check("mid_rst_no_entry", 64'(out_valid), 64'd0);

        // Signalling-sign NaN payload.
        drive(1'b1, 32'hFFC1_2345, 5'd0, 4'd9, 1'b0, 1'b0);
        cyc();
        drive(1'b0, '0, '0, '0, 1'b1, 1'b0);
`ifdef FP_ADD_RESULT_CANON_NAN_EN
        check("nan_canon", 64'(out_result), 64'h7FC0_0000);
`else
        check("nan_raw",   64'(out_result), 64'hFFC1_2345);
`endif
        cyc();

        // Randomized traffic; the compare process checks every cycle.
        for (int i = 0; i < 3000; i++) begin
            logic [W-1:0] r;
            r = W'($urandom);
            if ($urandom_range(0, 3) == 0)
                r = {r[W-1], {EXP{1'b1}}, r[FRAC-1:0] | FRAC'($urandom_range(0, 1))};
            rst = ($urandom_range(0, 199) == 0);
            drive(1'($urandom_range(0, 99) < 60), r, 5'($urandom), 4'($urandom),
                  1'($urandom_range(0, 99) < 55), 1'($urandom_range(0, 99) < 8));
            cyc();
        end
        rst = 1'b0;
        drive(1'b0, '0, '0, '0, 1'b1, 1'b0);
        cyc();
        cyc();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
